// File: rtl/lsu_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_master
// Brief    : CPU load/store unit bus master with byte/half extraction and
//            read-modify-write for sub-word stores.
// Revision : 1.0
// ============================================================================
module lsu_master #(
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ADDR_MASK = 32'h00000FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RD   = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;
    localparam logic [1:0] c_FIN  = 2'd3;

    localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_nextState;
    logic            r_we;
    logic            r_sext;
    logic [1:0]      r_size;
    logic [1:0]      r_lane;
    logic [31:0]     r_memAddr;
    logic [31:0]     r_memWdata;
    logic [31:0]     r_rdata;
    logic [c_CW-1:0] r_count;
    logic            r_gap;
    logic            r_alignErr;
    logic            r_busErr;

    logic            w_active;
    logic            w_ack;
    logic            w_timeout;
    logic            w_misalign;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_loadData;
    logic [31:0]     w_mergeData;

    // r_gap masks the request for one cycle after a read-phase ack of an RMW.
    assign w_active   = ((r_state == c_RD) || (r_state == c_WR)) && !r_gap;
    assign w_ack      = w_active && mem_ack;
    assign w_timeout  = w_active && !mem_ack && (r_count == c_LAST);
    assign w_misalign = (size == 2'b11) ||
                        ((size == 2'b01) && addr[0]) ||
                        ((size == 2'b00) && (addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE: begin
                if (req) begin
                    if (w_misalign) begin
                        w_nextState = c_FIN;
                    end else if (!we || (size != 2'b00)) begin
                        w_nextState = c_RD;
                    end else begin
                        w_nextState = c_WR;
                    end
                end
            end
            c_RD: begin
                if (w_ack) begin
                    w_nextState = r_we ? c_WR : c_FIN;
                end else if (w_timeout) begin
                    w_nextState = c_FIN;
                end
            end
            c_WR: begin
                if (w_ack || w_timeout) begin
                    w_nextState = c_FIN;
                end
            end
            default: w_nextState = c_IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != c_IDLE);
        done      = (r_state == c_FIN);
        mem_req   = w_active;
        mem_we    = (r_state == c_WR);
        align_err = (r_state == c_FIN) && r_alignErr;
        bus_err   = (r_state == c_FIN) && r_busErr;
    end

    assign rdata     = r_rdata;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

    always_comb begin
        w_byte      = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half      = mem_rdata[{r_lane[1], 4'b0000} +: 16];
        w_loadData  = mem_rdata;
        w_mergeData = mem_rdata;
        if (r_size == 2'b10) begin
            w_loadData = {{24{r_sext & w_byte[7]}}, w_byte};
            w_mergeData[{r_lane, 3'b000} +: 8] = r_memWdata[7:0];
        end else if (r_size == 2'b01) begin
            w_loadData = {{16{r_sext & w_half[15]}}, w_half};
            w_mergeData[{r_lane[1], 4'b0000} +: 16] = r_memWdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_sext     <= 1'b0;
            r_size     <= 2'b00;
            r_lane     <= 2'b00;
            r_memAddr  <= 32'd0;
            r_memWdata <= 32'd0;
            r_rdata    <= 32'd0;
            r_count    <= '0;
            r_gap      <= 1'b0;
            r_alignErr <= 1'b0;
            r_busErr   <= 1'b0;
        end else begin
            r_gap <= 1'b0;
            if ((r_state == c_IDLE) && req) begin
                r_we       <= we;
                r_sext     <= sext;
                r_size     <= size;
                r_lane     <= addr[1:0];
                r_memAddr  <= addr & ADDR_MASK;
                r_memWdata <= wdata;
                r_count    <= '0;
                r_alignErr <= w_misalign;
                r_busErr   <= 1'b0;
            end else if (w_ack) begin
                r_count <= '0;
                if (r_state == c_RD) begin
                    if (r_we) begin
                        r_memWdata <= w_mergeData;
                        r_gap      <= 1'b1;
                    end else begin
                        r_rdata <= w_loadData;
                    end
                end
            end else if (w_timeout) begin
                r_busErr <= 1'b1;
            end else if (w_active) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_master
// Brief    : Randomised bench for lsu_master against a word-memory model.
// Revision : 1.0
// ============================================================================
module tb_lsu_master;

    localparam int          c_TO   = 4;
    localparam logic [31:0] c_MASK = 32'h00000FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        align_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    lsu_master #(
        .TIMEOUT   (c_TO),
        .ADDR_MASK (c_MASK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sext      (sext),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .align_err (align_err),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    logic [31:0] r_mem [1024];
    logic [31:0] r_expRdata;
    int          nChecks = 0;
    int          nErrors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] a, input logic sx);
        logic [31:0] v;
        v = w;
        if (sz == 2'b10) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] m;
        int          sh;
        sh = (sz == 2'b10) ? 8 * a : 16 * a[1];
        m  = ((sz == 2'b10) ? 32'hFF : 32'hFFFF) << sh;
        return (w & ~m) | ((d << sh) & m);
    endfunction

    task automatic scramble_inputs();
        we    = 1'($urandom);
        size  = 2'($urandom);
        sext  = 1'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // Starts at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run_txn(input logic we_i, input logic [1:0] size_i, input logic sext_i,
                           input logic [31:0] addr_i, input logic [31:0] wdata_i,
                           input int dRd, input int dWr);
        int          idx, lat, reqExp, wrExp, cyc, reqCnt, wrCnt, phase;
        logic        mis, busExp, fin;
        logic [31:0] old, wrData;
        idx    = int'((addr_i & c_MASK) >> 2);
        old    = r_mem[idx];
        mis    = (size_i == 2'b11) || (size_i == 2'b01 && addr_i[0]) ||
                 (size_i == 2'b00 && addr_i[1:0] != 2'b00);
        busExp = 1'b0;
        wrExp  = 0;
        wrData = 32'd0;
        reqExp = 0;
        if (mis) begin
            lat = 2;
        end else if (!we_i) begin
            if (dRd < c_TO) begin
                lat = dRd + 3; reqExp = dRd + 1;
                r_expRdata = extract(old, size_i, addr_i[1:0], sext_i);
            end else begin
                lat = c_TO + 2; reqExp = c_TO; busExp = 1'b1;
            end
        end else if (size_i == 2'b00) begin
            if (dWr < c_TO) begin
                lat = dWr + 3; reqExp = dWr + 1; wrExp = 1; wrData = wdata_i;
            end else begin
                lat = c_TO + 2; reqExp = c_TO; busExp = 1'b1;
            end
        end else begin
            if (dRd >= c_TO) begin
                lat = c_TO + 2; reqExp = c_TO; busExp = 1'b1;
            end else if (dWr < c_TO) begin
                lat = dRd + dWr + 5; reqExp = dRd + dWr + 2; wrExp = 1;
                wrData = merge(old, wdata_i, size_i, addr_i[1:0]);
            end else begin
                lat = dRd + c_TO + 4; reqExp = dRd + 1 + c_TO; busExp = 1'b1;
            end
        end

        req = 1'b1; we = we_i; size = size_i; sext = sext_i; addr = addr_i; wdata = wdata_i;
        mem_ack = 1'b0;
        @(negedge clk);
        cyc = 2; reqCnt = 0; wrCnt = 0; phase = 0; fin = 1'b0;
        while (!fin) begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (done) begin
                check_val("latency", cyc, lat);
                check_val("align_err", align_err, mis);
                check_val("bus_err", bus_err, busExp);
                check_val("rdata", rdata, r_expRdata);
                check_val("reqCycles", reqCnt, reqExp);
                check_val("writes", wrCnt, wrExp);
                check_val("busyAtDone", busy, 1);
                fin = 1'b1;
            end else begin
                check_val("errNoDone", {align_err, bus_err}, 0);
                if (mem_req) begin
                    reqCnt++;
                    check_val("mem_addr", mem_addr, addr_i & c_MASK);
                    if (phase == (mem_we ? dWr : dRd)) begin
                        mem_ack = 1'b1;
                        if (mem_we) begin
                            wrCnt++;
                            check_val("wrData", mem_wdata, wrData);
                            r_mem[idx] = mem_wdata;
                        end else begin
                            mem_rdata = r_mem[idx];
                        end
                    end
                    phase++;
                end else begin
                    phase = 0;
                end
                if (cyc >= 40) begin
                    check_val("doneWithinBound", 0, 1);
                    fin = 1'b1;
                end
            end
            scramble_inputs();
            req = fin ? 1'b1 : 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        // req was high through the done cycle: it must not start a new access
        mem_ack = 1'($urandom);
        check_val("finNoAccept", {busy, done}, 0);
        req = 1'b0;
        @(negedge clk);
        check_val("idleAfter", {busy, done, mem_req}, 0);
        mem_ack = 1'b0;
    endtask

    task automatic reset_mid();
        int waitCyc;
        req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h14; wdata = 32'hDEADBEEF;
        @(negedge clk);
        req = 1'b0;
        waitCyc = 0;
        while (!mem_req && waitCyc < 10) begin
            @(negedge clk);
            waitCyc++;
        end
        check_val("reqBeforeReset", {mem_req, mem_we}, 2'b11);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rstCtl", {busy, done, mem_req, mem_we, align_err, bus_err}, 0);
        check_val("rstRdata", rdata, 0);
        check_val("rstAddr", mem_addr, 0);
        check_val("rstWdata", mem_wdata, 0);
        r_expRdata = 32'd0;
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            check_val("lateAckIgnored", {busy, done, mem_req}, 0);
        end
    endtask

    initial begin
        int dRd, dWr;
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
        addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        r_expRdata = 32'd0;
        for (int i = 0; i < 1024; i++) r_mem[i] = $urandom;
        repeat (2) @(negedge clk);
        check_val("resetCtl", {busy, done, mem_req, mem_we, align_err, bus_err}, 0);
        check_val("resetRdata", rdata, 0);
        reset = 1'b0;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("idleAckIgnored", {busy, done, mem_req}, 0);

        r_mem[4] = 32'h8899AABB;
        run_txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 0, 0);
        check_val("wordLoad", rdata, 32'h8899AABB);
        run_txn(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 0, 0);
        check_val("byteLoadSext", rdata, 32'hFFFFFF88);
        run_txn(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 0, 0);
        check_val("byteLoadZext", rdata, 32'h00000088);
        run_txn(1'b1, 2'b10, 1'b0, 32'h11, 32'h12345677, 0, 0);
        check_val("byteStoreMem", r_mem[4], 32'h889977BB);
        run_txn(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 0, 0);
        run_txn(1'b1, 2'b00, 1'b0, 32'h06, 32'h0, 0, 0);
        run_txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, c_TO, 0);
        run_txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, c_TO - 1, 0);
        check_val("ackAtLimit", rdata, 32'h889977BB);
        run_txn(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000CAFE, 1, c_TO);

        reset_mid();

        for (int n = 0; n < 300; n++) begin
            dRd = ($urandom_range(0, 7) == 0) ? c_TO : $urandom_range(0, c_TO - 1);
            dWr = ($urandom_range(0, 7) == 0) ? c_TO : $urandom_range(0, c_TO - 1);
            run_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom & 32'h0000F03F,
                    $urandom, dRd, dWr);
        end

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_master.md
LSU_MASTER -- requirements
Module: lsu_master

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT, default 16: maximum cycles to wait for mem_ack per memory phase.
- ADDR_MASK, default 32'h00000FFC: word-address bits forwarded to memory.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high.
- req  in  1  CPU access request, sampled in IDLE only.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 word, 01 half, 10 byte, 11 reserved.
- sext  in  1  sign-extend byte/half loads.
- addr  in  32  byte address.
- wdata  in  32  store data, low bits used for byte/half.
- busy  out  1  high from the accept cycle until the done cycle inclusive.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  load result, valid from done until the next accept.
- align_err  out  1  qualifies done for a misaligned or reserved access.
- bus_err  out  1  qualifies done for a timeout.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  equals addr & ADDR_MASK.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  read word, valid in the mem_ack cycle.
- mem_ack  in  1  memory completion, one-cycle pulse.

Function
REQ-003 The FSM SHALL have states IDLE, RD, WR, FIN; the state register SHALL be 2 bits.

REQ-004 In IDLE with req=1, the block SHALL latch we, size, sext, addr and wdata, and assert busy from the next cycle.

REQ-005 Alignment SHALL be checked at accept:
- size=01 with addr[0]=1 is misaligned.
- size=00 with addr[1:0]!=0 is misaligned.
- size=11 is invalid.
- Any of these SHALL go to FIN with align_err=1 and SHALL issue no memory access.

REQ-006 Next state after accept SHALL be:
- load: RD.
- word store: WR.
- byte or half store: RD, for read-modify-write.

REQ-007 In RD and WR, mem_req SHALL be 1, mem_we SHALL equal (state==WR), and mem_addr and mem_wdata SHALL stay stable until mem_ack.

REQ-008 On mem_ack in RD for a load, the block SHALL register the extracted data and go to FIN. Extraction:
- byte: lane addr[1:0], lane 0 = bits 7:0.
- half: lane addr[1], lane 0 = bits 15:0.
- Upper bits SHALL be zero-filled, or sign-filled when sext=1.

REQ-009 On mem_ack in RD for a sub-word store, the block SHALL merge wdata[7:0] or wdata[15:0] into the addressed lane of mem_rdata, keep the other lanes, register the result as mem_wdata, and go to WR.

REQ-010 On mem_ack in WR, the block SHALL go to FIN.

REQ-011 Mem_req SHALL deassert for at least the cycle after each ack, so RD→WR has one gap cycle with mem_req=0.

REQ-012 In FIN, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE. Req SHALL NOT be accepted in the FIN cycle.

REQ-013 Minimum latency, accept edge to done cycle, with ack in the first mem_req cycle, SHALL be:
- load: 3 cycles.
- word store: 3 cycles.
- sub-word store: 5 cycles.

REQ-014 A per-phase counter SHALL clear on entering RD or WR and increment each cycle without ack. When the count reaches TIMEOUT-1 with no ack, the block SHALL go to FIN with bus_err=1, drop mem_req, and leave rdata unchanged.

REQ-015 Mem_ack outside RD/WR SHALL be ignored. Req while busy SHALL be ignored and not queued.

REQ-016 An ack arriving in the same cycle the timeout is reached SHALL count as success, and bus_err SHALL stay 0.

REQ-017 Align_err and bus_err SHALL be 0 whenever done=0.

Reset
REQ-018 When reset=1 at a clock edge, the following SHALL hold after that edge, regardless of state:
- state=IDLE.
- busy=0, done=0, mem_req=0, mem_we=0.
- align_err=0, bus_err=0.
- rdata=0, mem_addr=0, mem_wdata=0, counter=0.

REQ-019 A reset mid-operation SHALL abandon the access with no done pulse. A mem_ack that arrives after the reset SHALL be ignored.

Verification
REQ-020 Word load: memory word 0x10 = 0x8899AABB, req load word addr=0x10, ack in first RD cycle → done at cycle 3, rdata=0x8899AABB, no write.

REQ-021 Byte load: addr=0x13, sext=1 → rdata=0xFFFFFF88. With sext=0 → rdata=0x00000088.

REQ-022 Byte store: memory word 0x10 = 0x8899AABB, store byte wdata=0x12345677 addr=0x11 → one read, one gap cycle, then a write of 0x8899 77BB (0x889977BB) to 0x10, done at cycle 5.

REQ-023 Misaligned: half load at addr=0x03 → done next cycle with align_err=1, mem_req never asserted. Word store at 0x06 → same response.

REQ-024 Timeout: TIMEOUT=4, load with mem_ack held 0 → mem_req high 4 cycles, then done with bus_err=1. A second run with ack on the 4th cycle → bus_err=0.

REQ-025 Reset in WR: reset pulsed while mem_req=1 → all outputs 0 after the edge, no done, and a late ack is ignored.
